// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment path.
// Split support is enabled by STORE_ALIGN_MISALIGNED_SPLIT_EN.
package store_align_unit_pkg;

  localparam int CPU_DATA_BITS = 32;
  localparam int STORE_WE_BITS = 4;

  localparam logic [1:0] STORE_SIZE_BYTE    = 2'b00;
  localparam logic [1:0] STORE_SIZE_HALF    = 2'b01;
  localparam logic [1:0] STORE_SIZE_WORD    = 2'b10;
  localparam logic [1:0] STORE_SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } store_state_t;

  // Byte-lane mask of an unshifted access of the given size.
  function automatic logic [STORE_WE_BITS-1:0] base_mask(
    input logic [1:0] size
  );
    logic [STORE_WE_BITS-1:0] m;
    m = '0;
    case (size)
      STORE_SIZE_BYTE: m = 4'b0001;
      STORE_SIZE_HALF: m = 4'b0011;
      STORE_SIZE_WORD: m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Places right-justified store data onto its byte lanes across
// an 8-byte window (two adjacent words).
module store_lane_shift
  import store_align_unit_pkg::*;
(
  input  logic [1:0]               i_size,
  input  logic [1:0]               i_off,
  input  logic [CPU_DATA_BITS-1:0] i_data,
  output logic [7:0]               o_mask8,
  output logic [63:0]              o_data64
);

  logic [CPU_DATA_BITS-1:0] w_dmask;
  logic [CPU_DATA_BITS-1:0] w_data;
  logic [4:0]               w_sh;

  // Zero the bytes above the access size so disabled lanes carry 0.
  always_comb begin
    w_dmask = '0;
    case (i_size)
      STORE_SIZE_BYTE: w_dmask = 32'h0000_00FF;
      STORE_SIZE_HALF: w_dmask = 32'h0000_FFFF;
      STORE_SIZE_WORD: w_dmask = 32'hFFFF_FFFF;
      default:         w_dmask = 32'h0000_0000;
    endcase
  end

  assign w_data   = i_data & w_dmask;
  assign w_sh     = {i_off, 3'b000};
  assign o_mask8  = {4'b0000, base_mask(i_size)} << i_off;
  assign o_data64 = {32'b0, w_data} << w_sh;

endmodule

// File: rtl/store_align_unit.sv
// Store request to lane-aligned data-memory beats.
// STORE_ALIGN_MISALIGNED_SPLIT_EN enables word-crossing splits.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_size,
  input  logic [ADDR_BITS-1:0]     req_addr,
  input  logic [DATA_BITS-1:0]     req_data,
  output logic                     dmem_valid,
  input  logic                     dmem_ready,
  output logic [ADDR_BITS-1:0]     dmem_addr,
  output logic [DATA_BITS-1:0]     dmem_wdata,
  output logic [STORE_WE_BITS-1:0] dmem_we,
  output logic                     store_done,
  output logic                     store_err
);

  store_state_t         r_state;
  logic [1:0]           r_size;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_err;

  logic [7:0]           w_mask8;
  logic [63:0]          w_data64;
  logic [ADDR_BITS-1:0] w_base;
  logic [1:0]           w_in_off;
  logic                 w_req_ok;

  store_lane_shift u_shift (
    .i_size   (r_size),
    .i_off    (r_addr[1:0]),
    .i_data   (r_data),
    .o_mask8  (w_mask8),
    .o_data64 (w_data64)
  );

  assign w_base   = {r_addr[ADDR_BITS-1:2], 2'b00};
  assign w_in_off = req_addr[1:0];

`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
  logic                 w_split;
  logic [ADDR_BITS-1:0] w_next;

  assign w_split  = |w_mask8[7:4];
  assign w_next   = w_base + ADDR_BITS'(4);
  assign w_req_ok = (req_size != STORE_SIZE_ILLEGAL);
`else
  logic w_unused_hi;

  assign w_unused_hi = ^{w_data64[63:32], w_mask8[7:4]};
  assign w_req_ok =
    (req_size == STORE_SIZE_BYTE) ||
    ((req_size == STORE_SIZE_HALF) && (w_in_off != 2'd3)) ||
    ((req_size == STORE_SIZE_WORD) && (w_in_off == 2'd0));
`endif

  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign store_done = r_done;
  assign store_err  = r_err;

  // Request latch, beat sequencing and completion/error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_size  <= STORE_SIZE_BYTE;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_req_ok) begin
              r_size  <= req_size;
              r_addr  <= req_addr;
              r_data  <= req_data;
              r_state <= S_BEAT0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_BEAT0: begin
          if (dmem_ready) begin
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
            if (w_split) begin
              r_state <= S_BEAT1;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
`else
            r_state <= S_IDLE;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
        S_BEAT1: begin
          if (dmem_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Beat fields come only from latched state, so they hold under stall.
  always_comb begin
    dmem_valid = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_we    = '0;
    case (r_state)
      S_BEAT0: begin
        dmem_valid = 1'b1;
        dmem_addr  = w_base;
        dmem_wdata = w_data64[31:0];
        dmem_we    = w_mask8[3:0];
      end
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
      S_BEAT1: begin
        dmem_valid = 1'b1;
        dmem_addr  = w_next;
        dmem_wdata = w_data64[63:32];
        dmem_we    = w_mask8[7:4];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit; follows the
// STORE_ALIGN_MISALIGNED_SPLIT_EN setting of the build.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        dmem_valid;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_we;
  logic        store_done;
  logic        store_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_align_unit #(.DATA_BITS(32), .ADDR_BITS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .dmem_valid (dmem_valid),
    .dmem_ready (dmem_ready),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .store_done (store_done),
    .store_err  (store_err)
  );

  task automatic issue(input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Captures the presented beat, stalls, then completes the handshake.
  task automatic do_beat(input int stall, output logic [68:0] obs,
                         output int unstable);
    obs = {dmem_valid, dmem_addr, dmem_we, dmem_wdata};
    unstable = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if ({dmem_valid, dmem_addr, dmem_we, dmem_wdata} !== obs)
        unstable++;
    end
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready got %b want 0", req_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({dmem_valid, dmem_addr, dmem_wdata, dmem_we, store_done,
         store_err, req_ready} !== {71'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_outs got v%b a%h d%h we%b dn%b er%b rdy%b",
               dmem_valid, dmem_addr, dmem_wdata, dmem_we,
               store_done, store_err, req_ready);
    end
    dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dmem_ready = 1'b0;
    n_cmp++;
    if ({dmem_valid, store_done, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL idle_ready got v%b dn%b rdy%b want 0 0 1",
               dmem_valid, store_done, req_ready);
    end
  endtask

  task automatic test_byte;
    logic [68:0] obs;
    int u;
    issue(2'b00, 32'h0000_1002, 32'hAABB_CCDD);
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_1000, 4'b0100, 32'h00DD_0000}) begin
      n_err++;
      $display("FAIL sb_beat got %h want %h", obs,
               {1'b1, 32'h0000_1000, 4'b0100, 32'h00DD_0000});
    end
    n_cmp++;
    if ({store_done, dmem_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL sb_done got dn%b v%b want 1 0",
               store_done, dmem_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (store_done !== 1'b0) begin
      n_err++;
      $display("FAIL sb_pulse got %b want 0", store_done);
    end
  endtask

  task automatic test_split_word;
    logic [68:0] obs;
    int u;
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
    issue(2'b10, 32'h0000_1003, 32'h1122_3344);
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_1000, 4'b1000, 32'h4400_0000}) begin
      n_err++;
      $display("FAIL sw_b0 got %h", obs);
    end
    n_cmp++;
    if (store_done !== 1'b0) begin
      n_err++;
      $display("FAIL sw_b0_done got %b want 0", store_done);
    end
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_1004, 4'b0111, 32'h0011_2233}) begin
      n_err++;
      $display("FAIL sw_b1 got %h", obs);
    end
    n_cmp++;
    if ({store_done, dmem_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL sw_done got dn%b v%b want 1 0",
               store_done, dmem_valid);
    end
`else
    issue(2'b10, 32'h0000_1003, 32'h1122_3344);
    n_cmp++;
    if ({store_err, dmem_valid, req_ready} !== 3'b101) begin
      n_err++;
      $display("FAIL sw_mis got er%b v%b rdy%b want 1 0 1",
               store_err, dmem_valid, req_ready);
    end
    obs = '0;
    u = 0;
    @(posedge clk); #1;
    n_cmp++;
    if ({store_err, dmem_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL sw_mis_after got er%b v%b want 0 0",
               store_err, dmem_valid);
    end
`endif
  endtask

  task automatic test_half_stall;
    logic [68:0] obs;
    int u;
    int extra;
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
    issue(2'b01, 32'h0000_2003, 32'h0000_BEEF);
    do_beat(3, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_2000, 4'b1000, 32'hEF00_0000} ||
        u != 0) begin
      n_err++;
      $display("FAIL sh_b0 got %h unstable %0d", obs, u);
    end
    do_beat(3, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_2004, 4'b0001, 32'h0000_00BE} ||
        u != 0) begin
      n_err++;
      $display("FAIL sh_b1 got %h unstable %0d", obs, u);
    end
`else
    issue(2'b01, 32'h0000_2002, 32'h0000_BEEF);
    do_beat(3, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_0000} ||
        u != 0) begin
      n_err++;
      $display("FAIL sh_stall got %h unstable %0d", obs, u);
    end
`endif
    n_cmp++;
    if (store_done !== 1'b1) begin
      n_err++;
      $display("FAIL sh_done got %b want 1", store_done);
    end
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dmem_valid !== 1'b0 || store_done !== 1'b0) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL sh_extra got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_wrap;
    logic [68:0] obs;
    int u;
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
    issue(2'b10, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000}) begin
      n_err++;
      $display("FAIL wrap_b0 got %h", obs);
    end
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_0000, 4'b0011, 32'h0000_CAFE}) begin
      n_err++;
      $display("FAIL wrap_b1 got %h", obs);
    end
`else
    issue(2'b10, 32'hFFFF_FFFC, 32'hCAFE_F00D);
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'hFFFF_FFFC, 4'b1111, 32'hCAFE_F00D}) begin
      n_err++;
      $display("FAIL wrap_sw got %h", obs);
    end
`endif
    n_cmp++;
    if (store_done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_done got %b want 1", store_done);
    end
  endtask

  task automatic test_illegal;
    issue(2'b11, 32'h0000_1000, 32'h1234_5678);
    n_cmp++;
    if ({store_err, dmem_valid, req_ready, store_done} !== 4'b1010) begin
      n_err++;
      $display("FAIL ill_size got er%b v%b rdy%b dn%b want 1 0 1 0",
               store_err, dmem_valid, req_ready, store_done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({store_err, dmem_valid, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL ill_after got er%b v%b rdy%b want 0 0 1",
               store_err, dmem_valid, req_ready);
    end
`ifndef STORE_ALIGN_MISALIGNED_SPLIT_EN
    issue(2'b10, 32'h0000_1001, 32'h1234_5678);
    n_cmp++;
    if ({store_err, dmem_valid, req_ready} !== 3'b101) begin
      n_err++;
      $display("FAIL ill_sw1 got er%b v%b rdy%b want 1 0 1",
               store_err, dmem_valid, req_ready);
    end
    issue(2'b01, 32'h0000_2003, 32'h0000_BEEF);
    n_cmp++;
    if ({store_err, dmem_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL ill_sh3 got er%b v%b want 1 0",
               store_err, dmem_valid);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid;
    logic [68:0] obs;
    int u;
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
    issue(2'b10, 32'h0000_1003, 32'h1122_3344);
    do_beat(0, obs, u);
`else
    issue(2'b10, 32'h0000_1000, 32'h1122_3344);
`endif
    n_cmp++;
    if (dmem_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rm_busy got %b want 1", dmem_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({dmem_valid, store_done} !== 2'b00) begin
      n_err++;
      $display("FAIL rm_drop got v%b dn%b want 0 0",
               dmem_valid, store_done);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({dmem_valid, store_done, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL rm_idle got v%b dn%b rdy%b want 0 0 1",
               dmem_valid, store_done, req_ready);
    end
    issue(2'b00, 32'h0000_1001, 32'h0000_005A);
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_1000, 4'b0010, 32'h0000_5A00} ||
        store_done !== 1'b1) begin
      n_err++;
      $display("FAIL rm_sb got %h dn%b", obs, store_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [68:0] obs;
    int u;
    issue(2'b01, 32'h0000_3001, 32'h1234_ABCD);
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_3000, 4'b0110, 32'h00AB_CD00} ||
        {store_done, req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_sh got %h dn%b rdy%b", obs, store_done,
               req_ready);
    end
    issue(2'b00, 32'h0000_1003, 32'hFFFF_FF77);
    do_beat(0, obs, u);
    n_cmp++;
    if (obs !== {1'b1, 32'h0000_1000, 4'b1000, 32'h7700_0000} ||
        store_done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_sb got %h dn%b", obs, store_done);
    end
  endtask

  initial begin
    test_reset;
    test_byte;
    test_split_word;
    test_half_stall;
    test_wrap;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
